// File: rtl/redundant_l3_resolve_pkg.sv
// Shared BN254 (d0) arithmetic parameters and operand types.
//   ADD_DIV        number of chunks a 12*M~ integer is split into
//   LEN_12M_TILDE  width of the resolved integer
//   L3_CARRY       width of the per-chunk redundant carry
//   W              chunk width (LEN_12M_TILDE / ADD_DIV)
// A redundant term is {carry, val}, so its value is carry*2^W + val.
package PARAMS_BN254_d0;

    localparam int unsigned ADD_DIV       = 4;
    localparam int unsigned LEN_12M_TILDE = 272;
    localparam int unsigned L3_CARRY      = 8;
    localparam int unsigned W             = LEN_12M_TILDE / ADD_DIV;
    localparam int unsigned OVF_W         = L3_CARRY + 1;

    typedef logic [W-1:0]             fp_div4_t;
    typedef logic [LEN_12M_TILDE-1:0] M_tilde12_t;

    typedef struct packed {
        logic [L3_CARRY-1:0] carry;
        fp_div4_t            val;
    } redundant_term_L3;

    // Term 0 occupies the least significant bits.
    typedef redundant_term_L3 [ADD_DIV-1:0] redundant_poly_L3;

endpackage

// File: rtl/redundant_l3_resolve_rdx_chunk_add.sv
// Combinational chunk adder used by the carry-resolve loop.
// Ports:
//   val    W-bit chunk value
//   carry  L3_CARRY-bit carry inherited from the previous term
//   c      1-bit running carry from the previous chunk
//   sum    low W bits of val + carry + c
//   cout   bit W of that sum (the new running carry)
module rdx_chunk_add
    import PARAMS_BN254_d0::*;
(
    input  fp_div4_t            val,
    input  logic [L3_CARRY-1:0] carry,
    input  logic                c,
    output fp_div4_t            sum,
    output logic                cout
);

    // Maximum is (2^W - 1) + (2^L3_CARRY - 1) + 1, which fits in W+1 bits.
    logic [W:0] s;

    always_comb begin
        s = {1'b0, val} + (W+1)'(carry) + (W+1)'(c);
    end

    assign sum  = s[W-1:0];
    assign cout = s[W];

endmodule

// File: rtl/redundant_l3_resolve.sv
// Resolves a redundant L3 polynomial into a plain integer, one chunk per
// cycle, with valid/ready handshakes on both sides.
// Ports:
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   in_valid   in_poly is valid
//   in_ready   block can accept a new operand (IDLE only)
//   in_poly    redundant operand, term i = {carry_i, val_i}
//   out_valid  out_uint/out_ovf are valid (DONE only)
//   out_ready  consumer accepts the result
//   out_uint   low LEN_12M_TILDE bits of the resolved integer
//   out_ovf    bits LEN_12M_TILDE and above of the resolved integer
module redundant_l3_resolve
    import PARAMS_BN254_d0::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  redundant_poly_L3 in_poly,
    output logic             out_valid,
    input  logic             out_ready,
    output M_tilde12_t       out_uint,
    output logic [OVF_W-1:0] out_ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    logic [1:0]              j;
    logic                    c;
    redundant_poly_L3        poly;
    fp_div4_t [ADD_DIV-1:0]  res;
    logic [OVF_W-1:0]        ovf;

    logic [L3_CARRY-1:0]     carry_in;
    fp_div4_t                sum;
    logic                    cout;

    // Chunk j absorbs the redundant carry of term j-1; chunk 0 has none.
    always_comb begin
        carry_in = '0;
        if (j != 2'd0) begin
            carry_in = poly[j - 2'd1].carry;
        end
    end

    rdx_chunk_add u_add (
        .val   (poly[j].val),
        .carry (carry_in),
        .c     (c),
        .sum   (sum),
        .cout  (cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            j     <= '0;
            c     <= 1'b0;
            poly  <= '0;
            res   <= '0;
            ovf   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        poly  <= in_poly;
                        j     <= '0;
                        c     <= 1'b0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    res[j] <= sum;
                    c      <= cout;
                    j      <= j + 2'd1;
                    if (j == 2'(ADD_DIV - 1)) begin
                        // Top term's carry plus the final running carry.
                        ovf   <= {1'b0, poly[ADD_DIV-1].carry} + OVF_W'(cout);
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_uint  = res;
    assign out_ovf   = ovf;

endmodule
